// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//     state_e      - loader FSM states (LEN, BASE, DATA, CSUM, DONE, ERR)
//     ERR_*        - err_code encodings reported on the loader's err_code port
//     HDR_BYTES    - byte count of each big-endian header word (LEN, BASE)
//     HDR_CNT_W    - width of the per-word header byte counter
//     frame_fits() - 33-bit bounds check of base + length against memory size
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_BASE = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_BOUNDS = 2'b01;
    localparam logic [1:0] ERR_CSUM   = 2'b10;

    localparam int HDR_BYTES = 4;
    localparam int HDR_CNT_W = $clog2(HDR_BYTES);

    // The sum is formed one bit wider than the header words so that a huge
    // LEN or BASE cannot wrap around and sneak past the bound.
    function automatic logic frame_fits(input logic [31:0] len,
                                        input logic [31:0] base,
                                        input logic [32:0] limit);
        logic [32:0] end_addr;
        end_addr = {1'b0, len} + {1'b0, base};
        return (end_addr <= limit);
    endfunction

endpackage

// File: rtl/be_word_assembler.sv
// ---------------------------------------------------------------------------
// be_word_assembler
//   Collects HDR_BYTES bytes, most significant byte first, into one word.
//
//   Ports:
//     clk_i    in   clock
//     reset_i  in   synchronous active-high reset (clears the byte count)
//     clr_i    in   clears count and word (used when the loader is re-armed)
//     shift_i  in   accept data_i as the next byte of the word
//     data_i   in   8-bit byte
//     word_o   out  assembled word; while shift_i is high it already
//                   includes data_i, so the last byte is usable in the same
//                   cycle it is accepted
//     last_o   out  high while the final byte of the word is being shifted in
// ---------------------------------------------------------------------------
module be_word_assembler
    import loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   shift_i,
    input  logic [7:0]             data_i,
    output logic [8*HDR_BYTES-1:0] word_o,
    output logic                   last_o
);

    logic [HDR_CNT_W-1:0]   cnt_q, cnt_d;
    logic [8*HDR_BYTES-1:0] word_q, word_d;
    logic [8*HDR_BYTES-1:0] word_shift;

    assign word_shift = {word_q[8*HDR_BYTES-9:0], data_i};
    assign last_o     = shift_i && !clr_i && (cnt_q == HDR_CNT_W'(HDR_BYTES - 1));
    assign word_o     = shift_i ? word_shift : word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (shift_i) begin
            cnt_d  = last_o ? '0 : cnt_q + 1'b1;
            word_d = word_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Word contents need no reset: a full word is always shifted in before
    // it is used, and the count restarts from zero on reset.
    always_ff @(posedge clk_i) begin
        word_q <= word_d;
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the byte-addressable instruction memory. Receives a
//   framed byte stream (LEN[4] BASE[4] payload[N] CSUM[1], big-endian header
//   words), writes the payload to consecutive addresses starting at BASE,
//   checks bounds and XOR checksum, and keeps the core in reset until a frame
//   has been loaded cleanly.
//
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-high reset
//     start      in   one-cycle pulse, re-arms the loader from DONE or ERR
//     in_valid   in   stream byte valid
//     in_data    in   stream byte
//     in_ready   out  byte accepted when in_valid && in_ready
//     mem_we     out  memory byte write strobe (one cycle after acceptance)
//     mem_addr   out  memory byte write address
//     mem_wdata  out  memory byte write data
//     core_hold  out  1 holds the fetch unit / core in reset
//     done       out  load finished with a matching checksum
//     error      out  load aborted
//     err_code   out  00 none, 01 out of bounds, 10 checksum mismatch
// ---------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter int unsigned ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    // A frame that passes the bounds check has N <= MEM_BYTES <= 2^ADDR_W,
    // so one extra bit above the address width holds any remaining count.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic [7:0]          acc_q, acc_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;

    logic                accept;
    logic                rearm;
    logic                len_shift, base_shift;
    logic                len_last, base_last;
    logic [31:0]         len_word, base_word;

    assign in_ready = (state_q == ST_LEN)  || (state_q == ST_BASE) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept   = in_valid && in_ready;
    assign rearm    = start && ((state_q == ST_DONE) || (state_q == ST_ERR));

    assign len_shift  = accept && (state_q == ST_LEN);
    assign base_shift = accept && (state_q == ST_BASE);

    be_word_assembler u_len_asm (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (rearm),
        .shift_i (len_shift),
        .data_i  (in_data),
        .word_o  (len_word),
        .last_o  (len_last)
    );

    be_word_assembler u_base_asm (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (rearm),
        .shift_i (base_shift),
        .data_i  (in_data),
        .word_o  (base_word),
        .last_o  (base_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_LEN: begin
                if (len_last) begin
                    state_d = ST_BASE;
                end
            end

            ST_BASE: begin
                // base_word already contains the byte being accepted, so the
                // bounds decision is taken on the 8th header byte itself.
                if (base_last) begin
                    if (!frame_fits(len_word, base_word, MEM_LIMIT)) begin
                        state_d = ST_ERR;
                        err_d   = ERR_BOUNDS;
                    end else begin
                        addr_d  = base_word[ADDR_W-1:0];
                        rem_d   = len_word[CNT_W-1:0];
                        state_d = (len_word == 32'd0) ? ST_CSUM : ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    acc_d   = acc_q ^ in_data;
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_CSUM;
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
            end

            ST_DONE, ST_ERR: begin
                if (rearm) begin
                    state_d = ST_LEN;
                    err_d   = ERR_NONE;
                    acc_d   = 8'h00;
                    rem_d   = '0;
                end
            end

            default: begin
                state_d = ST_LEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN;
            err_q   <= ERR_NONE;
            acc_q   <= 8'h00;
            rem_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Running write address is reloaded from BASE before every payload, so
    // it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign core_hold = (state_q != ST_DONE);
    assign err_code  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int unsigned MEM_BYTES = 1048576;
    localparam int unsigned ADDR_W    = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write,
    // including the cycle in which it was expected to appear.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_write actual addr=%0h data=%0h required no write (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr",  64'(mem_addr),  64'(e.addr));
                chk("wr_data",  64'(mem_wdata), 64'(e.data));
                chk("wr_cycle", 64'(cyc),       64'(e.cyc));
            end
        end else if (mem_we !== 1'b0) begin
            chk("wr_strobe_known", 64'(mem_we), 64'(0));
        end
    end

    // gap: -1 = exactly one idle cycle, 0 = none, >0 = random 0..gap idle
    // cycles. rs enables random (to-be-ignored) start pulses in idle cycles.
    task automatic put(input logic [7:0] b, input int gap, input bit rs, output int acc_cyc);
        int g;
        if (gap < 0)      g = 1;
        else if (gap > 0) g = $urandom_range(0, gap);
        else              g = 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = rs ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready_frame", 64'(in_ready), 64'(1));
        acc_cyc  = cyc + 1;
    endtask

    function automatic logic [7:0] pl_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int j = 0; j < n; j++) x ^= pl[j];
        return x;
    endfunction

    function automatic bit model_fits(input logic [31:0] len, input logic [31:0] base);
        return (longint'(len) + longint'(base)) <= longint'(MEM_BYTES);
    endfunction

    // Sends one frame; payload comes from pl. stop_after >= 0 abandons the
    // frame after that many payload bytes. Ends one negedge after the last
    // accepted byte with in_valid low.
    task automatic send_frame(input logic [31:0] len, input logic [31:0] base,
                              input logic [7:0] csum, input int gap, input bit rs,
                              input int stop_after);
        int c;
        bit abort = 1'b0;
        for (int i = 0; i < 4; i++) put(len[31-8*i -: 8], gap, rs, c);
        for (int i = 0; i < 4; i++) put(base[31-8*i -: 8], gap, rs, c);
        if (!model_fits(len, base)) abort = 1'b1;
        if (!abort) begin
            for (int j = 0; j < int'(len); j++) begin
                if (stop_after >= 0 && j == stop_after) begin
                    abort = 1'b1;
                    break;
                end
                put(pl[j], gap, rs, c);
                exp_q.push_back('{addr: base + 32'(j), data: pl[j], cyc: c});
            end
        end
        if (!abort) put(csum, gap, rs, c);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_end(input bit exp_done, input logic [1:0] exp_code, input string tag);
        chk({tag, "_done"},      64'(done),      64'(exp_done));
        chk({tag, "_error"},     64'(error),     64'(!exp_done));
        chk({tag, "_err_code"},  64'(err_code),  64'(exp_code));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(!exp_done));
        chk({tag, "_in_ready"},  64'(in_ready),  64'(0));
    endtask

    task automatic do_rearm(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_rearm_done"},  64'(done),      64'(0));
        chk({tag, "_rearm_error"}, 64'(error),     64'(0));
        chk({tag, "_rearm_code"},  64'(err_code),  64'(0));
        chk({tag, "_rearm_hold"},  64'(core_hold), 64'(1));
        chk({tag, "_rearm_ready"}, 64'(in_ready),  64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
        chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(1));
        chk({tag, "_done"},      64'(done),      64'(0));
        chk({tag, "_error"},     64'(error),     64'(0));
        chk({tag, "_err_code"},  64'(err_code),  64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Clean 4-byte load at address 0.
        pl = '{8'h4C, 8'h00, 8'h00, 8'h46};
        send_frame(32'd4, 32'd0, 8'h0A, 0, 1'b0, -1);
        check_end(1'b1, 2'b00, "t1");
        // Bytes offered while DONE must be refused.
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk("t1_done_ignores", 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_done_held", 64'(done), 64'(1));
        do_rearm("t1");

        // Same frame, wrong checksum.
        send_frame(32'd4, 32'd0, 8'h0B, 0, 1'b0, -1);
        check_end(1'b0, 2'b10, "t2");
        do_rearm("t2");

        // Out of bounds header: error right after the 8th header byte.
        send_frame(32'h10, 32'h000FFFF8, 8'h00, 0, 1'b0, -1);
        check_end(1'b0, 2'b01, "t3");
        do_rearm("t3");

        // Empty payload.
        pl = {};
        send_frame(32'd0, 32'h100, 8'h00, 0, 1'b0, -1);
        check_end(1'b1, 2'b00, "t4");
        do_rearm("t4");

        // in_valid toggling every cycle.
        pl = {};
        for (int j = 0; j < 8; j++) pl.push_back(8'($urandom));
        send_frame(32'd8, 32'd8, pl_xor(8), -1, 1'b0, -1);
        check_end(1'b1, 2'b00, "t5");
        do_rearm("t5");

        // Reset after two payload bytes, then a fresh frame.
        pl = {};
        for (int j = 0; j < 6; j++) pl.push_back(8'($urandom));
        send_frame(32'd6, 32'h40, pl_xor(6), 0, 1'b0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("t6_reset");
        @(negedge clk);
        chk("t6_no_we_after_reset", 64'(mem_we), 64'(0));
        pl = {};
        for (int j = 0; j < 5; j++) pl.push_back(8'($urandom));
        send_frame(32'd5, 32'h200, pl_xor(5), 0, 1'b0, -1);
        check_end(1'b1, 2'b00, "t6");
        do_rearm("t6");

        // Exact fit at the top of memory, and a zero-length frame at the end.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'd4, 32'(MEM_BYTES - 4), pl_xor(4), 0, 1'b0, -1);
        check_end(1'b1, 2'b00, "top");
        do_rearm("top");
        pl = {};
        send_frame(32'd0, 32'(MEM_BYTES), 8'h00, 0, 1'b0, -1);
        check_end(1'b1, 2'b00, "edge0");
        do_rearm("edge0");

        // Randomized frames with random gaps and ignored start pulses.
        for (int k = 0; k < 24; k++) begin
            int unsigned n;
            int          mode;
            logic [31:0] len;
            logic [31:0] base;
            logic [7:0]  cs;
            bit          fits;
            n    = $urandom_range(0, 12);
            mode = $urandom_range(0, 5);
            pl   = {};
            for (int j = 0; j < int'(n); j++) pl.push_back(8'($urandom));
            len = n;
            case (mode)
                0:       base = MEM_BYTES - n + $urandom_range(1, 64);
                1:       base = MEM_BYTES - n;
                2: begin
                    len  = 32'h8000_0000 | 32'($urandom);
                    base = $urandom;
                end
                default: base = $urandom_range(0, MEM_BYTES - n);
            endcase
            cs = pl_xor(int'(n));
            if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
            fits = model_fits(len, base);
            send_frame(len, base, cs, $urandom_range(0, 2), 1'b1, -1);
            if (!fits)                        check_end(1'b0, 2'b01, "rnd");
            else if (cs == pl_xor(int'(n)))   check_end(1'b1, 2'b00, "rnd");
            else                              check_end(1'b0, 2'b10, "rnd");
            do_rearm("rnd");
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressable instruction memory that the fetch unit reads.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte into memory at consecutive addresses.
- Checks bounds and checksum, and holds the core in reset until a load completes cleanly.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
- MEM_BYTES, 1048576: instruction memory size in bytes; the address bound.
- ADDR_W, 20: memory address width; must satisfy 2^ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- core_hold  out  1  drives the fetch/core reset; 1 = core held.
- done  out  1  level; load completed and checksum matched.
- error  out  1  level; load aborted.
- err_code  out  2  00 none, 01 out of bounds, 10 checksum mismatch.

Behaviour:
- Frame format, in order:
  - LEN: 4 bytes, big-endian, giving N = payload byte count.
  - BASE: 4 bytes, big-endian, giving the start byte address.
  - N payload bytes.
  - 1 checksum byte, equal to the XOR of all payload bytes (0x00 when N = 0).
- States: LEN, BASE, DATA, CSUM, DONE, ERR.
- Reset values: state = LEN; byte counter = 0; XOR accumulator = 0x00.
- Reset values of outputs: in_ready = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0, core_hold = 1, done = 0, error = 0, err_code = 00.
- in_ready is 1 in LEN, BASE, DATA and CSUM, and 0 in DONE and ERR. There is no back-pressure from memory.
- LEN and BASE:
  - A 2-bit counter counts accepted bytes; each byte shifts in MSB-first.
  - On the 4th BASE byte, compute base + N at 33-bit width.
  - If the result > MEM_BYTES, go to ERR with err_code 01.
  - Otherwise, if N == 0, go to CSUM; else go to DATA.
- DATA:
  - Each accepted byte produces mem_we = 1 on the next cycle (1-cycle latency), with mem_addr = base + index and mem_wdata = that byte.
  - The XOR accumulator updates on the same edge that accepts the byte.
  - After the Nth byte, go to CSUM.
  - Back-to-back bytes give back-to-back writes.
- CSUM:
  - On the accepted byte, if it equals the accumulator, go to DONE; else go to ERR with err_code 10.
  - The final DATA write completes (mem_we) in the same cycle CSUM is entered.
- DONE: done = 1, core_hold = 0. Incoming bytes are ignored (not accepted).
- ERR: error = 1, core_hold = 1. Memory contents already written are left as-is.
- start:
  - In DONE or ERR, start returns the FSM to LEN, clears done, error, err_code and the accumulator, and sets core_hold = 1 on the next cycle.
  - In any other state, start is ignored.
- Address arithmetic: base + index never wraps, since the bounds check guarantees the last address = MEM_BYTES-1 at most.
- reset mid-frame: immediate return to LEN with all reset values. Any partial write sequence is abandoned; no mem_we is issued in the cycle after reset.
- in_valid is sampled only when in_ready = 1. in_data is don't-care when in_valid = 0.

Decomposition:
- Shared package (loader_pkg):
  - state enum.
  - err_code constants ERR_NONE, ERR_BOUNDS, ERR_CSUM.
  - HDR_BYTES = 4.
- One natural sub-module: be_word_assembler, a 4-byte big-endian shift accumulator with a count and a word-complete flag, instantiated for LEN and BASE.

Test Plan:
- Stream LEN=00000004, BASE=00000000, payload 4C 00 00 46, csum 0x0A, one byte per cycle.
  - Four mem_we pulses at addr 0..3 with those bytes.
  - done = 1, core_hold = 0 one cycle after the csum byte; no error.
- Same frame with csum 0x0B -> error = 1, err_code = 10, core_hold stays 1, in_ready = 0.
- LEN=00000010, BASE=000FFFF8 with MEM_BYTES = 2^20 -> ERR with err_code = 01 immediately after the 8th header byte; zero mem_we pulses.
- LEN=00000000, BASE=00000100, csum 00 -> done = 1 with no writes. Then a start pulse -> done = 0, core_hold = 1, in_ready = 1 in LEN.
- Payload with in_valid toggling 1/0 every cycle at BASE=00000008 -> writes at 8, 9, 10, … each exactly one cycle after acceptance; no duplicate or missing writes.
- Assert reset after 2 payload bytes, then send a fresh full frame -> only the fresh frame's writes occur after reset; no stray mem_we in the cycle following reset; done = 1 at the end.
